// File: rtl/icache_fill.sv
// Direct-mapped I-cache with miss/fill FSM; optional hit/miss counters under ICACHE_STATS_EN.
// Latency: hit returns the cycle after the lookup edge; miss costs 1 + req wait + WORDS + 1 cycles.
// Backpressure: fe_stall holds fetch during a miss; mem_req_val/addr held stable until mem_req_rdy.
module icache_fill #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fe_req_val,
    input  logic [31:0] fe_pc,
    input  logic        fe_flush,
    output logic        fe_instr_val,
    output logic [31:0] fe_instr,
    output logic        fe_stall,
    output logic        mem_req_val,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_rdy,
    input  logic        mem_rsp_val,
    input  logic [31:0] mem_rsp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int WSEL = $clog2(WORDS);
    localparam int OFF  = WSEL + 2;
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 32 - OFF - IDX;
    localparam logic [WSEL-1:0] LAST_WORD = WSEL'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    logic [1:0]      state;
    logic            stgVal;
    logic [29:0]     stgWa;   // staged word address, pc[31:2]
    logic [WSEL-1:0] stgWord;
    logic [IDX-1:0]  stgIdx;
    logic [TAGW-1:0] stgTag;
    logic [WSEL-1:0] fillCnt;
    logic            hit;
    logic            idleMiss;
    logic            fillWr;
    logic            unusedPcBits;

    logic [LINES-1:0] lineVal;
    logic [TAGW-1:0]  tagMem  [LINES];
    logic [31:0]      dataMem [LINES][WORDS];

    assign unusedPcBits = ^fe_pc[1:0];

    assign stgWord = stgWa[WSEL-1:0];
    assign stgIdx  = stgWa[WSEL+IDX-1:WSEL];
    assign stgTag  = stgWa[29:WSEL+IDX];

    assign hit      = stgVal & lineVal[stgIdx] & (tagMem[stgIdx] == stgTag);
    assign idleMiss = (state == IDLE) & stgVal & ~hit;
    assign fillWr   = (state == FILL) & mem_rsp_val & ~reset;

    assign fe_stall     = (state != IDLE) | idleMiss;
    assign fe_instr_val = (state == IDLE) & hit;
    assign fe_instr     = fe_instr_val ? dataMem[stgIdx][stgWord] : 32'd0;
    assign mem_req_val  = (state == REQ);
    assign mem_req_addr = mem_req_val ? {stgWa[29:WSEL], {OFF{1'b0}}} : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            stgVal  <= 1'b0;
            lineVal <= '0;
            fillCnt <= '0;
        end else begin
            // A flush while stalled kills the held lookup; the fill itself still completes.
            if (!fe_stall)
                stgVal <= fe_req_val & ~fe_flush;
            else if (fe_flush)
                stgVal <= 1'b0;

            case (state)
                IDLE: if (idleMiss) state <= REQ;
                REQ: begin
                    if (mem_req_rdy) begin
                        fillCnt         <= '0;
                        lineVal[stgIdx] <= 1'b0;
                        state           <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rsp_val) begin
                        fillCnt <= fillCnt + WSEL'(1);
                        if (fillCnt == LAST_WORD) begin
                            lineVal[stgIdx] <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address, tags and data carry no reset; validity is tracked by stgVal/lineVal.
    always_ff @(posedge clk) begin
        if (!fe_stall)
            stgWa <= fe_pc[31:2];
        if (fillWr) begin
            dataMem[stgIdx][fillCnt] <= mem_rsp_data;
            if (fillCnt == LAST_WORD)
                tagMem[stgIdx] <= stgTag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (fe_instr_val)
                hit_cnt <= hit_cnt + 32'd1;
            if (idleMiss)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: table of hit vectors plus hand-written miss/fill sequences.
module tb_icache_fill;
    logic        clk = 1'b0;
    logic        reset;
    logic        fe_req_val;
    logic [31:0] fe_pc;
    logic        fe_flush;
    logic        fe_instr_val;
    logic [31:0] fe_instr;
    logic        fe_stall;
    logic        mem_req_val;
    logic [31:0] mem_req_addr;
    logic        mem_req_rdy;
    logic        mem_rsp_val;
    logic [31:0] mem_rsp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;
`endif

    int nChecks = 0;
    int nFails  = 0;

    icache_fill #(.LINES(16), .WORDS(4)) dut (
        .clk(clk), .reset(reset),
        .fe_req_val(fe_req_val), .fe_pc(fe_pc), .fe_flush(fe_flush),
        .fe_instr_val(fe_instr_val), .fe_instr(fe_instr), .fe_stall(fe_stall),
        .mem_req_val(mem_req_val), .mem_req_addr(mem_req_addr), .mem_req_rdy(mem_req_rdy),
        .mem_rsp_val(mem_rsp_val), .mem_rsp_data(mem_rsp_data)
`ifdef ICACHE_STATS_EN
        , .hit_cnt(hitCnt), .miss_cnt(missCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        flush;
        logic        expVal;
        logic [31:0] expInstr;
        logic        expStall;
    } vec_t;

    vec_t vecs[8];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered in the cycle right after a missing lookup was captured.
    task automatic doFill(input logic [31:0] addr, input int waitCyc,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input bit flushIt, input bit expHit, input logic [31:0] expInstr);
        logic [31:0] d[4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        check("miss_stall", 32'(fe_stall), 32'd1);
        check("miss_noval", 32'(fe_instr_val), 32'd0);
        check("miss_instr0", fe_instr, 32'd0);
        check("miss_noreq_yet", 32'(mem_req_val), 32'd0);
        cyc();
        for (int w = 0; w < waitCyc; w++) begin
            mem_rsp_val  = 1'b1;
            mem_rsp_data = 32'hDEAD0000 + 32'(w);
            check("wait_req_val", 32'(mem_req_val), 32'd1);
            check("wait_req_addr", mem_req_addr, addr);
            check("wait_stall", 32'(fe_stall), 32'd1);
            cyc();
        end
        mem_rsp_val = 1'b0;
        mem_req_rdy = 1'b1;
        check("req_val", 32'(mem_req_val), 32'd1);
        check("req_addr", mem_req_addr, addr);
        cyc();
        mem_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_val  = 1'b1;
            mem_rsp_data = d[i];
            fe_flush     = flushIt && (i == 1);
            check("fill_stall", 32'(fe_stall), 32'd1);
            check("fill_noreq", 32'(mem_req_val), 32'd0);
            cyc();
        end
        mem_rsp_val = 1'b0;
        fe_flush    = 1'b0;
        check("replay_val", 32'(fe_instr_val), 32'(expHit));
        check("replay_instr", fe_instr, expHit ? expInstr : 32'd0);
        check("replay_stall", 32'(fe_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h22, 1'b0};
        vecs[1] = '{1'b1, 32'h48, 1'b0, 1'b1, 32'h33, 1'b0};
        vecs[2] = '{1'b1, 32'h4C, 1'b0, 1'b1, 32'h44, 1'b0};
        vecs[3] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h11, 1'b0};
        vecs[4] = '{1'b0, 32'h48, 1'b0, 1'b0, 32'h0,  1'b0};
        vecs[5] = '{1'b1, 32'h48, 1'b1, 1'b0, 32'h0,  1'b0};
        vecs[6] = '{1'b1, 32'h4C, 1'b0, 1'b1, 32'h44, 1'b0};
        vecs[7] = '{1'b1, 32'h47, 1'b0, 1'b1, 32'h22, 1'b0};

        reset = 1'b1; fe_req_val = 1'b0; fe_pc = 32'h0; fe_flush = 1'b0;
        mem_req_rdy = 1'b0; mem_rsp_val = 1'b0; mem_rsp_data = 32'h0;
        cyc(); cyc(); cyc();
        reset = 1'b0;
        check("rst_instr_val", 32'(fe_instr_val), 32'd0);
        check("rst_instr", fe_instr, 32'd0);
        check("rst_stall", 32'(fe_stall), 32'd0);
        check("rst_req_val", 32'(mem_req_val), 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_cnt", hitCnt, 32'd0);
        check("rst_miss_cnt", missCnt, 32'd0);
`endif

        // Cold miss on 0x40
        fe_req_val = 1'b1; fe_pc = 32'h40;
        cyc();
        doFill(32'h40, 0, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b1, 32'h11);

        // Back-to-back hits from the table
        for (int i = 0; i < 8; i++) begin
            fe_req_val = vecs[i].req;
            fe_pc      = vecs[i].pc;
            fe_flush   = vecs[i].flush;
            cyc();
            check($sformatf("vec%0d_val", i), 32'(fe_instr_val), 32'(vecs[i].expVal));
            check($sformatf("vec%0d_instr", i), fe_instr, vecs[i].expInstr);
            check($sformatf("vec%0d_stall", i), 32'(fe_stall), 32'(vecs[i].expStall));
        end
        fe_flush = 1'b0;

        // Conflict miss 0x440 evicts 0x40; 0x40 then misses again with a 5-cycle request wait
        fe_req_val = 1'b1; fe_pc = 32'h440;
        cyc();
        doFill(32'h440, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 1'b0, 1'b1, 32'hA1);
        fe_pc = 32'h40;
        cyc();
        doFill(32'h40, 5, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b1, 32'h11);
        fe_pc = 32'h4C;
        cyc();
        check("after_wait_hit_val", 32'(fe_instr_val), 32'd1);
        check("after_wait_hit_instr", fe_instr, 32'h44);

        // Flush during fill of 0x80, then 0x84 hits
        fe_pc = 32'h80;
        cyc();
        doFill(32'h80, 0, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b1, 1'b0, 32'h0);
        fe_pc = 32'h84;
        cyc();
        check("flush_next_val", 32'(fe_instr_val), 32'd1);
        check("flush_next_instr", fe_instr, 32'hB1);
        check("flush_next_stall", 32'(fe_stall), 32'd0);

        // Reset after 2 of 4 fill words of 0xC0
        fe_pc = 32'hC0;
        cyc();
        check("rm_stall", 32'(fe_stall), 32'd1);
        cyc();
        mem_req_rdy = 1'b1;
        check("rm_req_addr", mem_req_addr, 32'hC0);
        cyc();
        mem_req_rdy = 1'b0;
        mem_rsp_val = 1'b1; mem_rsp_data = 32'hC0;
        cyc();
        mem_rsp_data = 32'hC1;
        cyc();
        reset = 1'b1; fe_req_val = 1'b0; mem_rsp_data = 32'hC2;
        cyc();
        reset = 1'b0; mem_rsp_data = 32'hC3;
        check("rm_idle_stall", 32'(fe_stall), 32'd0);
        check("rm_idle_req", 32'(mem_req_val), 32'd0);
        check("rm_idle_val", 32'(fe_instr_val), 32'd0);
        cyc();
        mem_rsp_val = 1'b0;
        check("rm_late_rsp_req", 32'(mem_req_val), 32'd0);
        check("rm_late_rsp_stall", 32'(fe_stall), 32'd0);
        fe_req_val = 1'b1; fe_pc = 32'hC0;
        cyc();
        doFill(32'hC0, 0, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 1'b0, 1'b1, 32'hD0);
        fe_pc = 32'hC8;
        cyc();
        check("refill_w2_val", 32'(fe_instr_val), 32'd1);
        check("refill_w2_instr", fe_instr, 32'hD2);
`ifdef ICACHE_STATS_EN
        check("stats_miss_cnt", missCnt, 32'd1);
        check("stats_hit_cnt", hitCnt, 32'd1);
`endif
        fe_req_val = 1'b0;
        cyc();
        check("end_idle_val", 32'(fe_instr_val), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
